// File: rtl/bram_pkg.sv
// Shared definitions for the bram_sdp_clr storage macro: read-collision modes,
// clear/run state encoding and the byte-lane merge helper.
package bram_pkg;

    localparam int unsigned RD_READ_FIRST  = 0;
    localparam int unsigned RD_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MERGE_W    = 1024;
    localparam int unsigned MERGE_BE_W = MERGE_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int unsigned b = 0; b < MERGE_BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Reset-free simple-dual-port storage array: byte-enable write, registered read,
// optional write-first bypass on same-address collisions.
module bram_sdp_core
    import bram_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned RD_MODE = RD_READ_FIRST
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              collide;

    assign collide = wr_en_i && (wr_addr_i == rd_addr_i);

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) begin
                    mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Read-first falls out of the registered read; write-first needs the bypass merge.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            if (RD_MODE == RD_WRITE_FIRST && collide) begin
                rd_data_o <= DATA_W'(merge_be(MERGE_W'(mem[rd_addr_i]),
                                              MERGE_W'(wr_data_i),
                                              MERGE_BE_W'(wr_be_i)));
            end else begin
                rd_data_o <= mem[rd_addr_i];
            end
        end
    end

endmodule

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port RAM with a sequential clear engine in place of an array reset,
// so the storage maps onto block RAM; optional output register.
module bram_sdp_clr
    import bram_pkg::*;
#(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DEPTH   = 256,
    parameter int unsigned       RD_MODE = RD_READ_FIRST,
    parameter int unsigned       OUT_REG = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clr_i,
    output logic                busy_o,
    input  logic                wr_en_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o
);

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                clearing;
    logic                wr_ok;
    logic                rd_acc;
    logic                rd_in_range;

    logic                core_we;
    logic [DATA_W/8-1:0] core_be;
    logic [ADDR_W-1:0]   core_waddr;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W-1:0]   core_rdata;

    logic                rd_vld_q;
    logic                rd_oor_q;
    logic                rd_seen_q;
    logic [DATA_W-1:0]   rd_word;

    assign clearing = (state == ST_CLEAR);
    assign busy_o   = clearing;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (clearing) begin
            if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                state   <= ST_RUN;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end else if (clr_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end
    end

    // A clear request drops any access presented in the same cycle.
    assign wr_ok       = !clearing && !clr_i && wr_en_i && (32'(wr_addr_i) < DEPTH);
    assign rd_acc      = !clearing && !clr_i && rd_en_i;
    assign rd_in_range = (32'(rd_addr_i) < DEPTH);

    assign core_we    = clearing || wr_ok;
    assign core_be    = clearing ? '1 : wr_be_i;
    assign core_waddr = clearing ? clr_cnt : wr_addr_i;
    assign core_wdata = clearing ? CLR_VAL : wr_data_i;

    bram_sdp_core #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RD_MODE (RD_MODE)
    ) u_core (
        .clk_i     (clk_i),
        .wr_en_i   (core_we),
        .wr_be_i   (core_be),
        .wr_addr_i (core_waddr),
        .wr_data_i (core_wdata),
        .rd_en_i   (rd_acc && rd_in_range),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (core_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_vld_q  <= 1'b0;
            rd_oor_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                rd_oor_q  <= !rd_in_range;
                rd_seen_q <= 1'b1;
            end
        end
    end

    // The array has no reset, so the output reads zero until the first accepted read.
    assign rd_word = !rd_seen_q ? '0 : (rd_oor_q ? CLR_VAL : core_rdata);

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] data_q;
            logic              vld_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        data_q <= rd_word;
                    end
                end
            end

            assign rd_data_o  = data_q;
            assign rd_valid_o = vld_q;
        end else begin : g_noreg
            assign rd_data_o  = rd_word;
            assign rd_valid_o = rd_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Scoreboard bench for bram_sdp_clr: two configurations share one stimulus stream,
// each checked against its own behavioural memory model.
module tb_bram_sdp_clr;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        clr;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        busy     [2];
    logic        rd_valid [2];
    logic [31:0] rd_data  [2];

    logic [31:0] mdl [2][256];
    int unsigned busy_left [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    bram_sdp_clr #(
        .DATA_W (32), .ADDR_W (8), .DEPTH (256),
        .RD_MODE (0), .OUT_REG (0), .CLR_VAL (32'h0000_0000)
    ) u_dut0 (
        .clk_i (clk), .rst_n_i (rst_n[0]), .clr_i (clr), .busy_o (busy[0]),
        .wr_en_i (wr_en), .wr_be_i (wr_be), .wr_addr_i (wr_addr), .wr_data_i (wr_data),
        .rd_en_i (rd_en), .rd_addr_i (rd_addr), .rd_data_o (rd_data[0]), .rd_valid_o (rd_valid[0])
    );

    bram_sdp_clr #(
        .DATA_W (32), .ADDR_W (8), .DEPTH (200),
        .RD_MODE (1), .OUT_REG (1), .CLR_VAL (32'hA5A5_A5A5)
    ) u_dut1 (
        .clk_i (clk), .rst_n_i (rst_n[1]), .clr_i (clr), .busy_o (busy[1]),
        .wr_en_i (wr_en), .wr_be_i (wr_be), .wr_addr_i (wr_addr), .wr_data_i (wr_data),
        .rd_en_i (rd_en), .rd_addr_i (rd_addr), .rd_data_o (rd_data[1]), .rd_valid_o (rd_valid[1])
    );

    function automatic int unsigned depth_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic logic [31:0] clrv_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'hA5A5_A5A5;
    endfunction

    function automatic int unsigned lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    // Model effect of the coming rising edge on configuration k.
    task automatic model_edge(input int k);
        exp_t        e;
        logic [31:0] rv;
        if (rst_n[k]) begin
            if (busy_left[k] > 0) begin
                busy_left[k]--;
            end else if (clr) begin
                busy_left[k] = depth_of(k);
                for (int i = 0; i < 256; i++) mdl[k][i] = clrv_of(k);
            end else begin
                if (rd_en) begin
                    if (32'(rd_addr) >= depth_of(k)) begin
                        rv = clrv_of(k);
                    end else begin
                        rv = mdl[k][rd_addr];
                        if (k == 1 && wr_en && wr_addr == rd_addr) rv = apply_be(rv, wr_data, wr_be);
                    end
                    e.due  = cyc + lat_of(k);
                    e.data = rv;
                    if (k == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                if (wr_en && 32'(wr_addr) < depth_of(k)) begin
                    mdl[k][wr_addr] = apply_be(mdl[k][wr_addr], wr_data, wr_be);
                end
            end
        end
    endtask

    task automatic monitor(input int k);
        exp_t e;
        logic ev;
        ev = 1'b0;
        e.due  = 0;
        e.data = '0;
        if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            e  = q0.pop_front();
            ev = 1'b1;
        end else if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            e  = q1.pop_front();
            ev = 1'b1;
        end
        check($sformatf("d%0d busy", k), 32'(busy[k]), 32'(busy_left[k] > 0));
        check($sformatf("d%0d rd_valid", k), 32'(rd_valid[k]), 32'(ev));
        if (ev && rd_valid[k]) check($sformatf("d%0d rd_data", k), rd_data[k], e.data);
    endtask

    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor(0);
        monitor(1);
    endtask

    task automatic op(input int we, input int be, input int wa, input logic [31:0] wd,
                      input int re, input int ra, input int c);
        wr_en   = (we != 0);
        wr_be   = 4'(be);
        wr_addr = 8'(wa);
        wr_data = wd;
        rd_en   = (re != 0);
        rd_addr = 8'(ra);
        clr     = (c != 0);
        cycle();
        wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && (busy_left[0] > 0 || busy_left[1] > 0); i++) cycle();
    endtask

    task automatic reset_dut(input logic m0, input logic m1);
        logic m [2];
        m[0] = m0;
        m[1] = m1;
        for (int k = 0; k < 2; k++) begin
            if (m[k]) begin
                rst_n[k]     = 1'b0;
                busy_left[k] = depth_of(k);
                for (int i = 0; i < 256; i++) mdl[k][i] = clrv_of(k);
                if (k == 0) q0.delete();
                else        q1.delete();
            end
        end
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            if (m[k]) begin
                check($sformatf("d%0d reset busy", k), 32'(busy[k]), 32'd1);
                check($sformatf("d%0d reset rd_valid", k), 32'(rd_valid[k]), 32'd0);
                check($sformatf("d%0d reset rd_data", k), rd_data[k], 32'h0);
                rst_n[k] = 1'b1;
            end
        end
    endtask

    initial begin
        int wa;
        int ra;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        clr = 1'b0; wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;

        reset_dut(1'b1, 1'b1);
        wait_idle();

        op(0, 0, 0, 32'h0, 1, 0, 0);
        op(0, 0, 0, 32'h0, 1, 255, 0);
        idle(3);

        op(1, 4'hF, 5, 32'hDEAD_BEEF, 0, 0, 0);
        op(1, 4'h2, 5, 32'h0000_AA00, 0, 0, 0);
        op(0, 0, 0, 32'h0, 1, 5, 0);
        idle(3);

        op(1, 4'hF, 7, 32'hFFFF_FFFF, 0, 0, 0);
        op(1, 4'h3, 7, 32'h1234_5678, 1, 7, 0);
        op(0, 0, 0, 32'h0, 1, 7, 0);
        op(1, 4'hF, 9, 32'hCAFE_F00D, 0, 0, 0);
        op(0, 0, 0, 32'h0, 1, 9, 0);
        op(1, 4'h0, 5, 32'h0BAD_0BAD, 0, 0, 0);
        op(0, 0, 0, 32'h0, 1, 5, 0);
        op(1, 4'hF, 220, 32'h1122_3344, 0, 0, 0);
        op(0, 0, 0, 32'h0, 1, 220, 0);
        idle(3);

        for (int i = 0; i < 10; i++) op(1, 4'hF, i, 32'h100 + 32'(i) * 32'h0101_0101, 0, 0, 0);
        for (int i = 0; i < 10; i++) op(0, 0, 0, 32'h0, 1, i, 0);
        idle(3);

        // Read just before the clear request must still complete.
        op(0, 0, 0, 32'h0, 1, 2, 0);
        op(1, 4'hF, 3, 32'h7777_7777, 1, 4, 1);
        for (int i = 0; i < 20; i++) op(1, 4'hF, i, $urandom, 1, i, (i == 5) ? 1 : 0);
        wait_idle();
        for (int i = 0; i < 256; i++) op(0, 0, 0, 32'h0, 1, i, 0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(195, 230)) : int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(195, 230)) : int'($urandom_range(0, 7));
            op(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), wa, $urandom,
               int'($urandom_range(0, 1)), ra, 0);
        end
        idle(3);

        // Second configuration is reset again part-way through its power-on clear.
        reset_dut(1'b1, 1'b1);
        idle(100);
        reset_dut(1'b0, 1'b1);
        wait_idle();
        for (int i = 0; i < 8; i++) op(0, 0, 0, 32'h0, 1, i * 33, 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_sdp_clr.md
Name: bram_sdp_clr

Overview:
Parametrised single-clock simple-dual-port RAM. One write port with byte enables, one read port with a valid strobe.
- Replaces whole-array async reset with a sequential clear engine, so the array maps to block RAM.
- Used as a generic storage macro under FIFOs, line buffers and register-file shadows in the datapath.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 8, address width
DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W
RD_MODE, 0, same-address collision policy: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data)
OUT_REG, 0, 1 adds an output register, raising read latency from 1 to 2
CLR_VAL, 0, DATA_W-bit word written to every location during clear

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
clr_i  in  1  single-cycle request to clear the whole array
busy_o  out  1  clear in progress; all accesses are ignored while high
wr_en_i  in  1  write request
wr_be_i  in  DATA_W/8  byte enables; bit b selects bits [8b+7:8b]
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  write data
rd_en_i  in  1  read request
rd_addr_i  in  ADDR_W  read address
rd_data_o  out  DATA_W  read data; holds its last value between reads, never tri-stated
rd_valid_o  out  1  one-cycle strobe per accepted read

Behaviour:
- FSM states: CLEAR and RUN, plus an ADDR_W-bit clear counter clr_cnt.
- Reset asserted (async):
  - state = CLEAR, clr_cnt = 0, busy_o = 1.
  - rd_valid_o = 0, rd_data_o = 0, OUT_REG pipeline flushed.
  - Array contents are not reset asynchronously.
- CLEAR:
  - Each rising edge writes CLR_VAL to mem[clr_cnt], then clr_cnt++.
  - The edge that writes DEPTH-1 moves to RUN; busy_o = 0 after that edge.
  - After reset release: DEPTH edges of busy.
  - Reset asserted mid-clear restarts the clear at address 0.
- RUN, clr_i = 1 sampled at edge N:
  - wr_en_i and rd_en_i at N are dropped.
  - Edges N+1..N+DEPTH clear addresses 0..DEPTH-1; busy_o is high across that window.
  - Reads accepted before N still complete with normal latency and rd_valid_o.
- clr_i is ignored in CLEAR; no restart.
- Write in RUN with wr_en_i = 1:
  - Each byte lane with wr_be_i[b] = 1 is updated.
  - wr_be_i = 0 leaves the word unchanged.
  - wr_addr_i >= DEPTH: write dropped.
- Read in RUN with rd_en_i = 1 at edge N:
  - OUT_REG = 0: rd_data_o updated and rd_valid_o = 1 after edge N.
  - OUT_REG = 1: same, after edge N+1.
  - Back-to-back reads are accepted every cycle, full throughput.
  - rd_addr_i >= DEPTH returns CLR_VAL with rd_valid_o = 1.
- Collision, same cycle, wr_addr_i == rd_addr_i:
  - RD_MODE = 0: returns the pre-write word.
  - RD_MODE = 1: returns the merged word (new bytes where wr_be_i is set, old bytes elsewhere).
  - Different addresses never interact.
- Write at edge N followed by a read of the same address at edge N+1 always returns the new data, in both modes.

Decomposition:
- Package bram_pkg:
  - RD_MODE constants RD_READ_FIRST / RD_WRITE_FIRST.
  - FSM state typedef {ST_CLEAR, ST_RUN}.
  - Byte-merge function merge_be(old, new, be).
- Sub-module bram_sdp_core:
  - Reset-free storage array with byte-enable write, registered read and collision bypass.
- Top level owns:
  - clear FSM and counter
  - clear/user write-port mux
  - out-of-range decode
  - optional output register and valid pipeline

Test Plan:
- Reset release, DEPTH=256 -> busy_o high for exactly 256 cycles; then read addr 0, 255 -> 0x00000000, rd_valid_o 1 cycle after rd_en_i.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then be=4'b0010 with data 0x0000AA00 -> read addr 5 returns 0xDEADAAEF.
- Same-cycle write 0x12345678 (be=4'b0011) and read of addr 7, where addr 7 holds 0xFFFFFFFF -> RD_MODE=0 returns 0xFFFFFFFF; RD_MODE=1 returns 0xFFFF5678.
- OUT_REG=1, reads of addresses 0..9 on consecutive cycles -> ten consecutive rd_valid_o pulses starting 2 cycles after the first rd_en_i, data in order.
- clr_i in RUN with CLR_VAL=0xA5A5A5A5:
  - Concurrent write is dropped; busy_o high for DEPTH cycles.
  - During busy, writes are ignored and rd_valid_o stays low.
  - Afterwards every address reads 0xA5A5A5A5.
- DEPTH=200, ADDR_W=8: write to addr 220 is dropped, read of addr 220 returns CLR_VAL; rst_n_i pulsed at clr_cnt=100 -> clear restarts, busy for 200 more cycles.
